i2s_rx_sync: RTL

Receives I2S audio (the codec ADC stream: BCLK, ADCLRC, ADCDAT) in the system clock domain and presents each completed stereo frame as a signed left/right pair with a valid/ready handshake. It is the capture counterpart of the I2S transmit path. It sits between the codec ADC pins and the DSP chain (multiplier, envelope and effect blocks). The I2S lines are oversampled rather than used as clocks, so all logic runs on one clock.

---
 rtl/i2s_rx_sync_if.sv | 14 +
 rtl/i2s_rx_sync.sv | 126 ++++++++++++
 2 files changed

// File: rtl/i2s_rx_sync_if.sv
// Stereo sample stream leaving the I2S receiver: a signed left/right pair
// with a valid/ready handshake and the sticky overflow flag.
interface i2s_rx_sync_if #(
    parameter int BITSIZE = 16
);
    logic signed [BITSIZE-1:0] left_chan;
    logic signed [BITSIZE-1:0] right_chan;
    logic                      valid;
    logic                      ready;
    logic                      overflow;

    modport master (output left_chan, right_chan, valid, overflow, input ready);
    modport slave  (input left_chan, right_chan, valid, overflow, output ready);
endinterface

// File: rtl/i2s_rx_sync.sv
// Oversampling I2S capture: BCLK/LRCLK/DATA are synchronised into clk and each
// complete left+right frame is presented as a pair. Optional I2S_RX_OVERFLOW_EN.
module i2s_rx_sync #(
    parameter int BITSIZE = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bclk,
    input  logic          lrclk,
    input  logic          sdata,
    i2s_rx_sync_if.master pair
);
    localparam int               CNT_W    = $clog2(BITSIZE + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITSIZE - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    typedef enum logic {CHAN_L = 1'b0, CHAN_R = 1'b1} chan_t;

    logic b_meta, b_s, b_d;
    logic lr_meta, lr_s;
    logic sd_meta, sd_s;

    state_t             state;
    chan_t              chan;
    logic [CNT_W-1:0]   bitcnt;
    logic               lr_prev;
    logic [BITSIZE-1:0] shreg;
    logic [BITSIZE-1:0] left_buf;

    logic               rise;
    logic               boundary;
    logic               pair_done;
    logic [BITSIZE-1:0] word;

    // Two flops per async pin; the third bclk flop only feeds edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_meta  <= 1'b0;
            b_s     <= 1'b0;
            b_d     <= 1'b0;
            lr_meta <= 1'b0;
            lr_s    <= 1'b0;
            sd_meta <= 1'b0;
            sd_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its predecessor, which is what turns this into a chain.
            b_meta  <= bclk;
            b_s     <= b_meta;
            b_d     <= b_s;
            lr_meta <= lrclk;
            lr_s    <= lr_meta;
            sd_meta <= sdata;
            sd_s    <= sd_meta;
        end
    end

    assign rise      = b_s & ~b_d;
    assign boundary  = rise && (lr_s != lr_prev);
    assign word      = {shreg[BITSIZE-2:0], sd_s};
    assign pair_done = rise && !boundary && (state == SHIFT) &&
                       (chan == CHAN_R) && (bitcnt == LAST_BIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            chan            <= CHAN_L;
            bitcnt          <= '0;
            lr_prev         <= 1'b0;
            shreg           <= '0;
            // NOTE: left_buf is a plain register, not a memory, so clearing it
            // on reset costs nothing and keeps the pair path free of X.
            left_buf        <= '0;
            pair.left_chan  <= '0;
            pair.right_chan <= '0;
            pair.valid      <= 1'b0;
        end else begin
            if (rise) begin
                lr_prev <= lr_s;
                if (boundary) begin
                    // The boundary edge is the one-bit delay slot: its data is dropped.
                    bitcnt <= '0;
                    if (!lr_s) begin
                        state <= SHIFT;
                        chan  <= CHAN_L;
                    end else if (state == HOLD && chan == CHAN_L) begin
                        state    <= SHIFT;
                        chan     <= CHAN_R;
                        left_buf <= shreg;
                    end else begin
                        // Short or orphaned left word: skip the right word too.
                        state <= IDLE;
                    end
                end else if (state == SHIFT) begin
                    shreg  <= word;
                    bitcnt <= bitcnt + 1'b1;
                    if (bitcnt == LAST_BIT) begin
                        state <= HOLD;
                    end
                end
            end

            // A fresh pair always wins, even in the cycle it is being accepted.
            if (pair_done) begin
                pair.left_chan  <= left_buf;
                pair.right_chan <= word;
                pair.valid      <= 1'b1;
            end else if (pair.valid && pair.ready) begin
                pair.valid <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVERFLOW_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair.overflow <= 1'b0;
        end else if (pair_done && pair.valid && !pair.ready) begin
            pair.overflow <= 1'b1;
        end
    end
`else
    assign pair.overflow = 1'b0;
`endif

endmodule
